// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between N_REQ byte producers, the arbiter and one uart_txd transmitter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic               busy;
  logic               txd_cmd;
  logic [7:0]         txd_data;
  logic               txd_flag;

  modport master (
    input  req, req_data, txd_flag,
    output gnt, done, err, busy, txd_cmd, txd_data
  );

  modport slave (
    output req, req_data, txd_flag,
    input  gnt, done, err, busy, txd_cmd, txd_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_txd among N_REQ byte producers, with inter-frame gap and watchdog.
// Latency: req sampled at edge t -> gnt/txd_cmd during cycle t+1; txd_flag at t -> done during t+1.
// Backpressure: requesters hold req until gnt; one byte in flight, next grant only after frame+gap.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk50M,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_owner, r_rr_ptr;
  logic [PW-1:0]    w_win, w_idx;
  logic             w_any;
  logic [WW-1:0]    r_wdog;
  logic [GW-1:0]    r_gap;
  logic [7:0]       r_txd_data;
  logic [N_REQ-1:0] r_gnt, r_done, r_err;
  logic             r_txd_cmd;
  logic             w_launch, w_fin_done, w_fin_err;

  // Scan from the farthest candidate back to rr_ptr so the nearest set bit is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % N_REQ);
      if (bus.req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A flag arriving with the watchdog terminal count is checked first, so it wins.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_fin_done  = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_launch    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.txd_flag) begin
          w_fin_done  = 1'b1;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_fin_err   = 1'b1;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_wdog     <= '0;
      r_gap      <= '0;
      r_txd_data <= 8'h00;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_txd_cmd  <= 1'b0;
    end else begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_txd_cmd <= w_launch;
      if (w_launch) begin
        r_owner       <= w_win;
        r_txd_data    <= bus.req_data[8*w_win +: 8];
        r_gnt[w_win]  <= 1'b1;
      end
      if (r_state == S_LAUNCH) begin
        r_wdog   <= '0;
        r_rr_ptr <= (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;
      end else if (r_state == S_WAIT) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_fin_done) r_done[r_owner] <= 1'b1;
      if (w_fin_err)  r_err[r_owner]  <= 1'b1;
      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.txd_cmd  = r_txd_cmd;
  assign bus.txd_data = r_txd_data;
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: stub transmitter, requester model and an expected-grant scoreboard.
// Expected grants are queued when bytes are posted and popped when the arbiter launches.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 32;
  localparam int FRAME = 10;

  logic clk50M = 1'b0;
  logic rst_n;
  always #10 clk50M = ~clk50M;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] dat;
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  int         posted[N];
  int         served[N];
  logic [N-1:0] drv_req;
  int         stub_mode = 0;
  int         flag_at = FRAME;
  int         wait_cnt = -1;
  int         req_rise_cyc = 0;
  int         flag_cyc = 0;

  exp_t       mon_e;
  int         cur_idx = 0;
  logic [7:0] cur_dat = 8'h00;
  bit         cur_to = 1'b0;
  bit         open = 1'b0;
  int         cmd_cyc = 0;
  int         last_cmd_cyc = 0;
  bit         last_valid = 1'b0;
  bit         spacing_on = 1'b0;
  bit         lat_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk50M) cyc = cyc + 1;

  // Requesters and stub transmitter; flag_at counts WAIT cycles after the txd_cmd cycle.
  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.txd_flag = 1'b0;
    forever begin
      @(negedge clk50M);
      for (int i = 0; i < N; i++) if (bus.gnt[i]) served[i]++;
      for (int i = 0; i < N; i++) drv_req[i] = (posted[i] != served[i]);
      if (bus.req == '0 && drv_req != '0) req_rise_cyc = cyc;
      bus.req = drv_req;
      bus.txd_flag = 1'b0;
      if (!rst_n) wait_cnt = -1;
      else if (bus.txd_cmd) wait_cnt = 0;
      else if (wait_cnt >= 0) begin
        wait_cnt++;
        if (stub_mode == 0 && wait_cnt == flag_at) begin
          bus.txd_flag = 1'b1;
          flag_cyc     = cyc;
          wait_cnt     = -1;
        end
      end
    end
  end

  // Monitor: launches pop the scoreboard; done/err are checked against the open frame.
  initial begin
    forever begin
      @(negedge clk50M);
      if (!rst_n) begin
        open = 1'b0;
        continue;
      end
      if (bus.txd_cmd || bus.gnt != '0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_launch", {27'd0, bus.txd_cmd, bus.gnt}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("gnt", bus.gnt, 32'd1 << mon_e.idx);
          check_val("txd_cmd", bus.txd_cmd, 1);
          check_val("txd_data", bus.txd_data, mon_e.dat);
          if (spacing_on && last_valid) check_val("spacing", cyc - last_cmd_cyc, FRAME + GAP + 2);
          if (lat_on) check_val("req_latency", cyc - req_rise_cyc, 1);
          last_cmd_cyc = cyc;
          last_valid   = spacing_on;
          cmd_cyc      = cyc;
          cur_idx      = mon_e.idx;
          cur_dat      = mon_e.dat;
          cur_to       = mon_e.to;
          open         = 1'b1;
        end
      end
      if (bus.done != '0 || bus.err != '0) begin
        if (!open) begin
          check_val("stray_end", {24'd0, bus.done, bus.err}, 32'd0);
        end else begin
          check_val("done", bus.done, cur_to ? 32'd0 : (32'd1 << cur_idx));
          check_val("err", bus.err, cur_to ? (32'd1 << cur_idx) : 32'd0);
          check_val("data_hold", bus.txd_data, cur_dat);
          // Error surfaces TMO cycles after the txd_cmd cycle ends.
          if (cur_to) check_val("err_time", cyc - cmd_cyc, TMO + 1);
          else        check_val("done_latency", cyc - flag_cyc, 1);
          open = 1'b0;
        end
      end
    end
  end

  task automatic post(input int idx, input logic [7:0] dat, input bit to);
    bus.req_data[8*idx +: 8] = dat;
    exp_q.push_back('{idx, dat, to});
    posted[idx]++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.req != '0 || open) && n < budget) begin
      @(negedge clk50M);
      n++;
    end
    check_val({tag, "_queue_empty"}, exp_q.size(), 0);
    check_val({tag, "_idle"}, {31'd0, bus.busy}, 0);
    @(negedge clk50M);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_gnt"}, bus.gnt, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_err"}, bus.err, 0);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_txd_cmd"}, bus.txd_cmd, 0);
    check_val({tag, "_txd_data"}, bus.txd_data, 8'h00);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk50M);
    check_quiet("reset");
    #2 rst_n = 1'b1;
    @(negedge clk50M);

    // Everyone requesting, requester 0 twice: 0,1,2,3,0 at minimum spacing.
    spacing_on = 1'b1;
    post(0, 8'hA0, 1'b0);
    post(1, 8'hA1, 1'b0);
    post(2, 8'hA2, 1'b0);
    post(3, 8'hA3, 1'b0);
    post(0, 8'hA0, 1'b0);
    drain("all4", 400);
    spacing_on = 1'b0;

    lat_on = 1'b1;
    post(1, 8'h55, 1'b0);
    drain("single", 100);
    lat_on = 1'b0;

    // rr_ptr is 2 after serving 1: req 1011 -> 3, 0, 1.
    post(3, 8'hB3, 1'b0);
    post(0, 8'hB0, 1'b0);
    post(1, 8'hB1, 1'b0);
    drain("rotate", 300);

    stub_mode = 1;
    post(2, 8'hC2, 1'b1);
    drain("watchdog", 200);
    stub_mode = 0;

    flag_at = TMO;
    post(3, 8'hD3, 1'b0);
    drain("flag_vs_tc", 200);
    flag_at = FRAME;

    // Abort mid-WAIT; rr_ptr would be 2 without reset, so 0 must win first afterwards.
    stub_mode = 1;
    post(1, 8'hE1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk50M);
      n++;
    end
    check_val("midwait_launch_seen", exp_q.size(), 0);
    repeat (5) @(negedge clk50M);
    check_val("midwait_busy", {31'd0, bus.busy}, 1);
    #2 rst_n = 1'b0;
    #1 check_quiet("midwait_reset");
    stub_mode = 0;
    post(2, 8'hF2, 1'b0);
    post(0, 8'hF0, 1'b0);
    exp_q.delete();
    exp_q.push_back('{0, 8'hF0, 1'b0});
    exp_q.push_back('{2, 8'hF2, 1'b0});
    repeat (3) @(negedge clk50M);
    #2 rst_n = 1'b1;
    drain("after_reset", 300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
